// File: rtl/knight_cmd_pkg.sv
// Shared opcode/heading constants and executor state type for the knight command path.
package knight_cmd_pkg;

  localparam logic [2:0] CMD_CAL  = 3'b000;
  localparam logic [2:0] CMD_MOVE = 3'b010;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    TURN,
    RAMP_UP,
    RAMP_DOWN
  } exec_state_t;

endpackage

// File: rtl/move_cmd_exec_line_counter.sv
// Counts cntrIR rising edges (two per square) and flags when the commanded distance is covered.
module line_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       cntrIR,
  input  logic [3:0] squares,
  output logic       sq_done
);

  logic       cntr_q;
  logic [4:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cntr_q <= 1'b0;
      count  <= '0;
    end else begin
      cntr_q <= cntrIR;
      if (clr)
        count <= '0;
      else if (en && cntrIR && !cntr_q)
        count <= count + 5'd1;
    end
  end

  assign sq_done = (count == {squares, 1'b0});

endmodule

// File: rtl/move_cmd_exec.sv
// Executes one calibrate or move command at a time, driving desired heading and forward speed.
module move_cmd_exec
  import knight_cmd_pkg::*;
#(
  parameter logic [9:0]  FRWRD_INC = 10'h010,
  parameter logic [9:0]  MAX_SPD   = 10'h2A0,
  parameter logic [11:0] HDG_TOL   = 12'h02C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cal_done,
  input  logic        cntrIR,
  output logic        strt_cal,
  output logic [11:0] dsrd_hdng,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare_go
);

  exec_state_t state, state_n;

  logic        fan_q, fan_q_n;
  logic [3:0]  sq_q, sq_q_n;
  logic [11:0] dsrd_n;
  logic [9:0]  frwrd_n;
  logic        moving_n, clr_n, resp_n, cal_n, fan_n;
  logic        cnt_clr, sq_done;

  logic [11:0] err, abs_err;
  logic        in_tol;
  logic [10:0] up_sum, dec;
  logic [9:0]  up_val, dn_val;

  line_counter u_line_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (state == RAMP_UP),
    .cntrIR  (cntrIR),
    .squares (sq_q),
    .sq_done (sq_done)
  );

  // Heading error wraps modulo 4096; the magnitude is compared unsigned.
  assign err     = heading - dsrd_hdng;
  assign abs_err = err[11] ? (12'd0 - err) : err;
  assign in_tol  = (abs_err < HDG_TOL);

  assign up_sum = {1'b0, frwrd} + {1'b0, FRWRD_INC};
  assign up_val = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
  assign dec    = {FRWRD_INC, 1'b0};
  assign dn_val = ({1'b0, frwrd} >= dec) ? (frwrd - dec[9:0]) : '0;

  always_comb begin
    state_n  = state;
    fan_q_n  = fan_q;
    sq_q_n   = sq_q;
    dsrd_n   = dsrd_hdng;
    frwrd_n  = frwrd;
    moving_n = moving;
    clr_n    = 1'b0;
    resp_n   = 1'b0;
    cal_n    = 1'b0;
    fan_n    = 1'b0;
    cnt_clr  = 1'b0;
    case (state)
      IDLE: begin
        // Blocking while an ack or response is still out keeps a held cmd_rdy from re-triggering.
        if (cmd_rdy && !clr_cmd_rdy && !send_resp) begin
          fan_q_n = cmd[12];
          sq_q_n  = cmd[3:0];
          clr_n   = 1'b1;
          case (cmd[15:13])
            CMD_CAL: begin
              cal_n   = 1'b1;
              state_n = CAL;
            end
            CMD_MOVE: begin
              dsrd_n   = {cmd[11:4], 4'h0};
              cnt_clr  = 1'b1;
              moving_n = 1'b1;
              frwrd_n  = '0;
              state_n  = TURN;
            end
            default: resp_n = 1'b1;
          endcase
        end
      end
      CAL: begin
        if (cal_done) begin
          resp_n  = 1'b1;
          state_n = IDLE;
        end
      end
      TURN: begin
        frwrd_n = '0;
        if (in_tol)
          state_n = RAMP_UP;
      end
      RAMP_UP: begin
        if (heading_rdy)
          frwrd_n = up_val;
        if (sq_done) begin
          fan_n   = fan_q;
          state_n = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (heading_rdy)
          frwrd_n = dn_val;
        if (frwrd == '0) begin
          moving_n = 1'b0;
          resp_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fan_q       <= 1'b0;
      sq_q        <= '0;
      dsrd_hdng   <= '0;
      frwrd       <= '0;
      moving      <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      strt_cal    <= 1'b0;
      fanfare_go  <= 1'b0;
    end else begin
      state       <= state_n;
      fan_q       <= fan_q_n;
      sq_q        <= sq_q_n;
      dsrd_hdng   <= dsrd_n;
      frwrd       <= frwrd_n;
      moving      <= moving_n;
      clr_cmd_rdy <= clr_n;
      send_resp   <= resp_n;
      strt_cal    <= cal_n;
      fanfare_go  <= fan_n;
    end
  end

endmodule

// File: tb/tb_move_cmd_exec.sv
// Randomized self-checking bench for move_cmd_exec against a behavioural speed/heading model.
module tb_move_cmd_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        cmd_rdy = 1'b0;
  logic [11:0] heading = '0;
  logic        heading_rdy = 1'b0;
  logic        cal_done = 1'b0;
  logic        cntrIR = 1'b0;
  logic        clr_cmd_rdy, send_resp, strt_cal, moving, fanfare_go;
  logic [11:0] dsrd_hdng;
  logic [9:0]  frwrd;

  int total = 0;
  int bad = 0;
  int n_resp = 0, n_fan = 0, n_cal = 0;

  always #5 clk = ~clk;

  move_cmd_exec #(.FRWRD_INC(10'h010), .MAX_SPD(10'h2A0), .HDG_TOL(12'h02C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .cal_done    (cal_done),
    .cntrIR      (cntrIR),
    .strt_cal    (strt_cal),
    .dsrd_hdng   (dsrd_hdng),
    .frwrd       (frwrd),
    .moving      (moving),
    .fanfare_go  (fanfare_go)
  );

  // Reference model: signed heading error modulo 4096 and speed arithmetic.
  function automatic bit ref_in_tol(int h, int d);
    int e;
    e = (h - d + 8192) % 4096;
    if (e >= 2048) e = e - 4096;
    if (e < 0) e = -e;
    return (e < 44);
  endfunction

  function automatic int ref_up(int f);
    return (f + 16 > 672) ? 672 : f + 16;
  endfunction

  function automatic int ref_down(int f);
    return (f >= 32) ? f - 32 : 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    if (send_resp)  n_resp++;
    if (fanfare_go) n_fan++;
    if (strt_cal)   n_cal++;
  endtask

  task automatic accept(input logic [15:0] c, output logic s_resp, output logic s_cal,
                        output logic s_mov, output logic [11:0] s_dsrd);
    cmd = c;
    cmd_rdy = 1'b1;
    tick;
    s_resp = send_resp;
    s_cal = strt_cal;
    s_mov = moving;
    s_dsrd = dsrd_hdng;
    total++;
    if (clr_cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL accept_clr cmd=%h got=%b want=1", c, clr_cmd_rdy);
    end
    cmd_rdy = 1'b0;
    cmd = 16'($urandom);
    tick;
    total++;
    if (clr_cmd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL clr_one_cycle cmd=%h got=%b want=0", c, clr_cmd_rdy);
    end
  endtask

  task automatic ramp_up(input int n, inout int f);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      heading_rdy = 1'b1;
      tick;
      heading_rdy = 1'b0;
      f = ref_up(f);
      total++;
      if (frwrd !== 10'(f)) begin
        bad++;
        $display("FAIL ramp_up step=%0d got=%h want=%h", i, frwrd, f);
      end
    end
  endtask

  task automatic lines(input int sq, input bit fan);
    int fan0;
    fan0 = n_fan;
    for (int i = 0; i < 2 * sq; i++) begin
      if (i == 2 * sq - 1) begin
        total++;
        if (n_fan != fan0) begin
          bad++;
          $display("FAIL fanfare_early got=%0d want=0", n_fan - fan0);
        end
      end
      cntrIR = 1'b1;
      tick;
      tick;
      if (i == 2 * sq - 1) begin
        total++;
        if (fanfare_go !== fan) begin
          bad++;
          $display("FAIL fanfare_at_last_edge got=%b want=%b", fanfare_go, fan);
        end
      end
      cntrIR = 1'b0;
      tick;
      tick;
    end
    tick;
    total++;
    if (n_fan - fan0 != int'(fan)) begin
      bad++;
      $display("FAIL fanfare_count got=%0d want=%0d", n_fan - fan0, fan);
    end
  endtask

  task automatic ramp_down_and_finish(input int f, input int r0, input logic [11:0] exp_dsrd);
    int guard;
    total++;
    if (frwrd !== 10'(f)) begin
      bad++;
      $display("FAIL hold_during_lines got=%h want=%h", frwrd, f);
    end
    while (f > 0) begin
      heading_rdy = 1'b1;
      tick;
      heading_rdy = 1'b0;
      f = ref_down(f);
      total++;
      if (frwrd !== 10'(f)) begin
        bad++;
        $display("FAIL ramp_down got=%h want=%h", frwrd, f);
      end
    end
    guard = 0;
    while (n_resp == r0 && guard < 8) begin
      tick;
      guard++;
    end
    total++;
    if (n_resp != r0 + 1) begin
      bad++;
      $display("FAIL move_resp got=%0d want=1", n_resp - r0);
    end
    total++;
    if (moving !== 1'b0 || frwrd !== 10'd0) begin
      bad++;
      $display("FAIL move_end got moving=%b frwrd=%h want 0/0", moving, frwrd);
    end
    total++;
    if (dsrd_hdng !== exp_dsrd) begin
      bad++;
      $display("FAIL dsrd_held got=%h want=%h", dsrd_hdng, exp_dsrd);
    end
    repeat (2) tick;
  endtask

  task automatic run_move(input logic [15:0] c, input int nup);
    logic s_resp, s_cal, s_mov;
    logic [11:0] s_dsrd, exp_dsrd;
    int f, r0;
    exp_dsrd = {c[11:4], 4'h0};
    r0 = n_resp;
    accept(c, s_resp, s_cal, s_mov, s_dsrd);
    total++;
    if (s_dsrd !== exp_dsrd || s_mov !== 1'b1 || s_resp !== 1'b0) begin
      bad++;
      $display("FAIL move_accept cmd=%h got dsrd=%h mov=%b resp=%b want %h/1/0",
               c, s_dsrd, s_mov, s_resp, exp_dsrd);
    end
    f = 0;
    ramp_up(nup, f);
    lines(int'(c[3:0]), c[12]);
    ramp_down_and_finish(f, r0, exp_dsrd);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    total++;
    if ({clr_cmd_rdy, send_resp, strt_cal, fanfare_go, moving, dsrd_hdng, frwrd} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got clr=%b resp=%b cal=%b fan=%b mov=%b dsrd=%h frwrd=%h want all 0",
               clr_cmd_rdy, send_resp, strt_cal, fanfare_go, moving, dsrd_hdng, frwrd);
    end
    rst_n = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_calibrate;
    logic s_resp, s_cal, s_mov;
    logic [11:0] s_dsrd;
    int r0, c0;
    r0 = n_resp;
    c0 = n_cal;
    accept(16'h0000, s_resp, s_cal, s_mov, s_dsrd);
    total++;
    if (s_cal !== 1'b1 || s_resp !== 1'b0) begin
      bad++;
      $display("FAIL cal_start got cal=%b resp=%b want 1/0", s_cal, s_resp);
    end
    repeat (19) tick;
    cal_done = 1'b1;
    tick;
    cal_done = 1'b0;
    total++;
    if (send_resp !== 1'b1 || n_resp != r0 + 1) begin
      bad++;
      $display("FAIL cal_resp got=%b count=%0d want 1/1", send_resp, n_resp - r0);
    end
    tick;
    total++;
    if (send_resp !== 1'b0 || n_cal != c0 + 1) begin
      bad++;
      $display("FAIL cal_pulses got resp=%b cal_count=%0d want 0/1", send_resp, n_cal - c0);
    end
    repeat (2) tick;
  endtask

  task automatic test_move_north;
    heading = 12'h000;
    run_move(16'h4002, 60);
  endtask

  task automatic test_turn(input logic [7:0] d8, input logic [3:0] sq, input bit use_fixed);
    logic s_resp, s_cal, s_mov;
    logic [11:0] s_dsrd, d;
    logic [11:0] probes[$];
    int f, r0;
    bit passed;
    d = {d8, 4'h0};
    heading = d + 12'h800;
    r0 = n_resp;
    accept({3'b010, 1'b0, d8, sq}, s_resp, s_cal, s_mov, s_dsrd);
    total++;
    if (s_dsrd !== d) begin
      bad++;
      $display("FAIL turn_dsrd got=%h want=%h", s_dsrd, d);
    end
    if (use_fixed) begin
      probes.push_back(12'hBF0);
      probes.push_back(d + 12'd44);
      probes.push_back(d - 12'd44);
      probes.push_back(12'h3E0);
      probes.push_back(12'hFF0);
    end else begin
      repeat (3) probes.push_back(d + 12'($urandom_range(44, 4052)));
      probes.push_back(d + 12'd44);
      probes.push_back(d - 12'd44);
      probes.push_back(d + 12'($urandom_range(0, 43)));
      probes.push_back(d - 12'($urandom_range(0, 43)));
    end
    passed = 1'b0;
    f = 0;
    foreach (probes[i]) begin
      if (!passed) begin
        heading = probes[i];
        tick;
        heading_rdy = 1'b1;
        tick;
        heading_rdy = 1'b0;
        if (ref_in_tol(int'(probes[i]), int'(d))) begin
          passed = 1'b1;
          f = ref_up(0);
        end
        total++;
        if (frwrd !== 10'(f)) begin
          bad++;
          $display("FAIL turn_gate hdg=%h dsrd=%h got=%h want=%h", probes[i], d, frwrd, f);
        end
      end
    end
    ramp_up(3, f);
    lines(int'(sq), 1'b0);
    ramp_down_and_finish(f, r0, d);
  endtask

  task automatic test_fanfare_and_zero;
    heading = 12'h7F0;
    run_move(16'h57F1, 5);
    heading = 12'h000;
    run_move(16'h4000, 0);
    heading = 12'h000;
    run_move(16'h5000, 0);
  endtask

  task automatic test_illegal;
    logic s_resp, s_cal, s_mov;
    logic [11:0] s_dsrd;
    logic [2:0] ops[6];
    ops = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    accept(16'hE000, s_resp, s_cal, s_mov, s_dsrd);
    total++;
    if (s_resp !== 1'b1 || s_mov !== 1'b0 || s_cal !== 1'b0) begin
      bad++;
      $display("FAIL illegal_E000 got resp=%b mov=%b cal=%b want 1/0/0", s_resp, s_mov, s_cal);
    end
    repeat (2) tick;
    repeat (4) begin
      accept({ops[$urandom_range(0, 5)], 13'($urandom)}, s_resp, s_cal, s_mov, s_dsrd);
      total++;
      if (s_resp !== 1'b1 || s_mov !== 1'b0) begin
        bad++;
        $display("FAIL illegal_rand got resp=%b mov=%b want 1/0", s_resp, s_mov);
      end
      repeat (2) tick;
    end
  endtask

  task automatic test_reset_mid;
    logic s_resp, s_cal, s_mov;
    logic [11:0] s_dsrd;
    int f, r0;
    heading = 12'h000;
    accept(16'h4003, s_resp, s_cal, s_mov, s_dsrd);
    f = 0;
    ramp_up(16, f);
    total++;
    if (frwrd !== 10'h100) begin
      bad++;
      $display("FAIL pre_reset_frwrd got=%h want=100", frwrd);
    end
    r0 = n_resp;
    rst_n = 1'b0;
    tick;
    total++;
    if ({clr_cmd_rdy, send_resp, strt_cal, fanfare_go, moving, dsrd_hdng, frwrd} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got mov=%b dsrd=%h frwrd=%h want all 0",
               moving, dsrd_hdng, frwrd);
    end
    rst_n = 1'b1;
    repeat (10) tick;
    total++;
    if (n_resp != r0) begin
      bad++;
      $display("FAIL reset_no_resp got=%0d want=0", n_resp - r0);
    end
    accept(16'hE000, s_resp, s_cal, s_mov, s_dsrd);
    total++;
    if (s_resp !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset got resp=%b want=1", s_resp);
    end
    repeat (2) tick;
  endtask

  task automatic test_random_moves;
    logic [7:0] h8;
    logic [3:0] sq;
    bit fan;
    int off;
    repeat (5) begin
      h8 = 8'($urandom);
      sq = 4'($urandom_range(0, 3));
      fan = 1'($urandom);
      off = $urandom_range(0, 40) - 20;
      heading = {h8, 4'h0} + 12'(off);
      run_move({3'b010, fan, h8, sq}, (sq == 0) ? 0 : $urandom_range(1, 50));
    end
    repeat (2) test_turn(8'($urandom), 4'($urandom_range(1, 2)), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_calibrate;
    test_move_north;
    test_turn(8'h3F, 4'd1, 1'b1);
    test_turn(8'h00, 4'd1, 1'b1);
    test_fanfare_and_zero;
    test_illegal;
    test_reset_mid;
    test_random_moves;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
